// File: rtl/usb_pad_conditioner_if.sv
// Gamepad-report / arcade-control bundle for usb_pad_conditioner.
// master: gamepad receiver side (drives report and strobe, observes controls).
// slave : conditioner side (consumes report, drives the core's control inputs).
interface usb_pad_conditioner_if;
    logic [7:0] usb_gamepad_data;
    logic       usb_gamepad_ena;
    logic [3:0] i_sw;
    logic [3:0] i_button;
    logic       link_ok;

    modport master (
        output usb_gamepad_data,
        output usb_gamepad_ena,
        input  i_sw,
        input  i_button,
        input  link_ok
    );

    modport slave (
        input  usb_gamepad_data,
        input  usb_gamepad_ena,
        output i_sw,
        output i_button,
        output link_ok
    );
endinterface

// File: rtl/usb_pad_conditioner.sv
// USB gamepad report conditioner for the arcade core's I_SW / I_BUTTON inputs.
// Latches reports, releases all controls on link loss, locks out opposing
// directions, stretches SELECT into a fixed-width coin pulse.
// Optional autofire on the A button when USB_PAD_AUTOFIRE_EN is defined.
module usb_pad_conditioner #(
    parameter int unsigned TIMEOUT_CYC    = 2400000,
    parameter int unsigned COIN_PULSE_CYC = 2400000,
    parameter int unsigned AUTOFIRE_HALF  = 800000
) (
    input  logic                 clk24,
    input  logic                 rst_n,
    usb_pad_conditioner_if.slave pad
);
    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned COIN_W = $clog2(COIN_PULSE_CYC + 1);

    // Every cycle count must be at least one for the counters to make sense.
    if (TIMEOUT_CYC == 0 || COIN_PULSE_CYC == 0 || AUTOFIRE_HALF == 0) begin : g_bad_cfg
        $error("usb_pad_conditioner: cycle parameters must be nonzero");
    end

    logic [7:0]        rpt;
    logic [WD_W-1:0]   wd_cnt;
    logic              stale;

    logic [COIN_W-1:0] coin_cnt;
    logic [COIN_W-1:0] coin_next;
    logic              sel_prev;
    logic              sel_rise;

    logic              up;
    logic              down;
    logic              left;
    logic              right;
    logic              j1_next;

    logic [3:0]        sw_q;
    logic [3:0]        button_q;
    logic              link_q;

    // Report latch and link watchdog; a strobe always beats the timeout.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            rpt    <= '0;
            wd_cnt <= '0;
            stale  <= 1'b1;
        end else if (pad.usb_gamepad_ena) begin
            rpt    <= pad.usb_gamepad_data;
            wd_cnt <= '0;
            stale  <= 1'b0;
        end else if (wd_cnt >= WD_W'(TIMEOUT_CYC - 1)) begin
            wd_cnt <= WD_W'(TIMEOUT_CYC);
            stale  <= 1'b1;
            rpt    <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Direction lockout per axis and coin counter next value.
    always_comb begin
        up        = rpt[4] & ~rpt[5];
        down      = rpt[5] & ~rpt[4];
        left      = rpt[6] & ~rpt[7];
        right     = rpt[7] & ~rpt[6];
        sel_rise  = rpt[2] & ~sel_prev;
        coin_next = coin_cnt;
        if (coin_cnt != '0) begin
            coin_next = coin_cnt - COIN_W'(1);
        end else if (sel_rise) begin
            coin_next = COIN_W'(COIN_PULSE_CYC);
        end
    end

`ifdef USB_PAD_AUTOFIRE_EN
    localparam int unsigned AF_W = $clog2(AUTOFIRE_HALF + 1);

    logic [AF_W-1:0] af_cnt;
    logic [AF_W-1:0] af_cnt_next;
    logic            af_fire;
    logic            af_fire_next;
    logic            a_prev;

    // Autofire phase: restart firing on each A press, toggle every half-period.
    always_comb begin
        af_cnt_next  = af_cnt;
        af_fire_next = af_fire;
        if (!rpt[0]) begin
            af_cnt_next  = '0;
            af_fire_next = 1'b0;
        end else if (!a_prev) begin
            af_cnt_next  = AF_W'(AUTOFIRE_HALF - 1);
            af_fire_next = 1'b1;
        end else if (af_cnt == '0) begin
            af_cnt_next  = AF_W'(AUTOFIRE_HALF - 1);
            af_fire_next = ~af_fire;
        end else begin
            af_cnt_next  = af_cnt - AF_W'(1);
        end
    end

    // Autofire phase registers.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            af_cnt  <= '0;
            af_fire <= 1'b0;
            a_prev  <= 1'b0;
        end else begin
            af_cnt  <= af_cnt_next;
            af_fire <= af_fire_next;
            a_prev  <= rpt[0];
        end
    end

    assign j1_next = ~af_fire_next;
`else
    assign j1_next = ~rpt[0];
`endif

    // Coin pulse state and registered control outputs.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            coin_cnt <= '0;
            sel_prev <= 1'b0;
            sw_q     <= 4'b1100;
            button_q <= 4'b1111;
            link_q   <= 1'b0;
        end else begin
            coin_cnt <= coin_next;
            sel_prev <= rpt[2];
            sw_q     <= {~rpt[1], j1_next, (coin_next != '0), rpt[3]};
            button_q <= {~right, ~left, ~down, ~up};
            link_q   <= ~stale;
        end
    end

    assign pad.i_sw     = sw_q;
    assign pad.i_button = button_q;
    assign pad.link_ok  = link_q;
endmodule

// File: doc/usb_pad_conditioner.md
# usb_pad_conditioner

Conditions raw USB gamepad reports into the arcade core's switch/joystick inputs. Sits between the USB gamepad receiver (8-bit report plus one-cycle valid strobe) and the game core's `I_SW[3:0]` / `I_BUTTON[3:0]` inputs. Provides:
- report latching
- link-loss watchdog that releases all controls
- opposing-direction lockout
- minimum-width coin pulse
- optional autofire

## Interface
Parameters:
- `TIMEOUT_CYC`, default 2400000: cycles without a report before link is declared lost (100 ms at 24 MHz).
- `COIN_PULSE_CYC`, default 2400000: width of the generated coin pulse, in cycles.
- `AUTOFIRE_HALF`, default 800000: autofire half-period, in cycles. Used only with `AUTOFIRE_EN`.

Ports:
- `clk24` in 1: system clock, 24 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `usb_gamepad_data` in 8: report, active-high. Bit assignments:
  - [0] A, [1] B, [2] SELECT, [3] START
  - [4] UP, [5] DOWN, [6] LEFT, [7] RIGHT
- `usb_gamepad_ena` in 1: one-cycle strobe. `usb_gamepad_data` is valid while it is high.
- `i_sw` out 4: {J2, J1, C1, S1}.
  - J2, J1 are active-low fire buttons.
  - C1 (coin) and S1 (start) are active-high.
- `i_button` out 4: {R1, L1, D1, U1}, all active-low.
- `link_ok` out 1: high while reports are arriving within `TIMEOUT_CYC`.

## Operation
Report latching:
- On each clock with `usb_gamepad_ena`=1, `rpt` <= `usb_gamepad_data`. The watchdog counter clears and `stale` clears.
- `ena` is ignored while `rst_n`=0.

Watchdog:
- `wd_cnt` increments each cycle without `ena` and saturates at `TIMEOUT_CYC`.
- When `wd_cnt` reaches `TIMEOUT_CYC`, `stale` <= 1 and `rpt` <= 0.
- `ena` in the same cycle wins: the counter clears and the report is taken.
- `stale`=1 after reset until the first report arrives.
- `link_ok` = ~`stale`, registered.

Direction lockout:
- UP and DOWN both set: both treated as released.
- LEFT and RIGHT both set: both treated as released.
- The axes are independent.

Output mapping:
- U1 = ~UP, D1 = ~DOWN, L1 = ~LEFT, R1 = ~RIGHT, each after lockout.
- J2 = ~B.
- J1 = ~A, or the autofire result when `AUTOFIRE_EN` is defined.
- S1 = START.
- C1 = coin pulse.

Coin pulse:
- A rising edge of `rpt[2]` (current vs previous latched value) loads `coin_cnt` = `COIN_PULSE_CYC`.
- C1 = (`coin_cnt` != 0). The counter decrements each cycle.
- Rising edges while `coin_cnt` != 0 are ignored. No retrigger and no extension.
- Link loss does not abort a pulse in progress.
- SELECT held continuously produces exactly one pulse.

Widths:
- Counters are `$clog2(param+1)` bits and never wrap.

## Timing
- All outputs are registered.
- Latency: `ena` at edge N updates `rpt` at N; the corresponding outputs change at edge N+1.
- Coin: SELECT rising edge latched at N → C1=1 from N+1 for exactly `COIN_PULSE_CYC` cycles.
- Watchdog: last `ena` at edge N → `stale` set at edge N+`TIMEOUT_CYC` → released outputs and `link_ok`=0 at N+`TIMEOUT_CYC`+1.
- Reset values (asynchronous, immediate):
  - `i_sw` = 4'b1100, `i_button` = 4'b1111, `link_ok` = 0
  - `rpt` = 0, all counters 0, `stale` = 1
- Reset asserted mid-pulse or mid-autofire aborts it immediately.
- Reset deassertion takes effect at the next `clk24` edge.

## Configuration
`USB_PAD_AUTOFIRE_EN`:
- Defined:
  - While A is held, J1 toggles every `AUTOFIRE_HALF` cycles.
  - The phase counter restarts on each A press, so J1 goes low (fire) one cycle after the press latch and is held low for `AUTOFIRE_HALF` cycles, then high for `AUTOFIRE_HALF` cycles.
  - A released → J1=1 on the next edge.
- Undefined:
  - J1 = ~A as a level, 1-cycle latency.
  - No autofire counter is synthesized.

## Test plan
Parameters for the bench: `TIMEOUT_CYC`=100, `COIN_PULSE_CYC`=10, `AUTOFIRE_HALF`=4.
1. Reset → `i_sw`=4'b1100, `i_button`=4'b1111, `link_ok`=0. First `ena` with data 8'h00 → `link_ok`=1 after 2 edges.
2. `ena` with data 8'h18 (START+UP) → next cycle `i_sw`=4'b1101, `i_button`=4'b1110. Data 8'h30 (UP+DOWN) → `i_button`=4'b1111.
3. SELECT held across 5 reports (8'h04) → C1 high for exactly 10 cycles, once. Release then press → a second pulse. A press during an active pulse → no extension.
4. Report 8'hFF, then no `ena` for 100 cycles → all outputs released (`i_sw`=4'b1100 unless a coin pulse is active, `i_button`=4'b1111), `link_ok`=0. `ena` on the timeout cycle → no release.
5. `USB_PAD_AUTOFIRE_EN` defined, A held 20 cycles → J1 pattern 0000111100001111… Undefined → J1 constant 0. Release → J1=1 next edge.
6. `rst_n` low mid coin pulse → C1=0 immediately. After release, no pulse until a new SELECT rising edge.
